// File: rtl/ics_miss_refill_pkg.sv
// Shared constants and FSM encoding for the instruction-cache miss refill path.
package ics_miss_refill_pkg;

    localparam int DEF_ADDR_WIDTH = 16;
    localparam int DEF_WORD_WIDTH = 16;
    localparam int DEF_LINE_WORDS = 4;
    localparam int DEF_NUM_SETS   = 64;

    // Refill FSM states; IDLE must stay at zero so o_miss_state is just "state != 0".
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_FILL   = 2'd2,
        ST_TAG_WR = 2'd3
    } refill_state_e;

endpackage

// File: rtl/ics_miss_refill_beat_cnt.sv
// Beat counter for one line burst: clear at burst start, step on each accepted beat.
module ics_miss_refill_beat_cnt #(
    parameter int LINE_WORDS  = 4,
    parameter int OFFSET_BITS = $clog2(LINE_WORDS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_clr,
    input  logic                   i_en,
    output logic [OFFSET_BITS-1:0] o_count,
    output logic                   o_last
);

    logic [OFFSET_BITS-1:0] cnt_q, cnt_d;

    // Next count: clear wins over step; the last step wraps naturally to zero.
    always_comb begin
        cnt_d = cnt_q;
        if (i_clr)
            cnt_d = '0;
        else if (i_en)
            cnt_d = cnt_q + OFFSET_BITS'(1);
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign o_count = cnt_q;
    assign o_last  = (cnt_q == OFFSET_BITS'(LINE_WORDS - 1));

endmodule

// File: rtl/ics_miss_refill.sv
// Instruction-cache miss responder: captures a miss, bursts the line in from
// memory, writes every data word, then writes the tag and releases the miss.
module ics_miss_refill
    import ics_miss_refill_pkg::*;
#(
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int WORD_WIDTH  = DEF_WORD_WIDTH,
    parameter int LINE_WORDS  = DEF_LINE_WORDS,
    parameter int NUM_SETS    = DEF_NUM_SETS,
    parameter int OFFSET_BITS = $clog2(LINE_WORDS),
    parameter int INDEX_BITS  = $clog2(NUM_SETS),
    parameter int TAG_WIDTH   = ADDR_WIDTH - INDEX_BITS - OFFSET_BITS
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_halt,
    input  logic [ADDR_WIDTH-1:0]  i_miss_addr,
    input  logic                   i_miss_valid,
    output logic                   o_miss_ready,
    output logic                   o_miss_state,
    output logic [ADDR_WIDTH-1:0]  o_mem_req_addr,
    output logic                   o_mem_req_valid,
    input  logic                   i_mem_req_ready,
    input  logic [WORD_WIDTH-1:0]  i_mem_rsp_data,
    input  logic                   i_mem_rsp_valid,
    output logic                   o_mem_rsp_ready,
    output logic                   o_data_we,
    output logic [INDEX_BITS-1:0]  o_data_index,
    output logic [OFFSET_BITS-1:0] o_data_offset,
    output logic [WORD_WIDTH-1:0]  o_data_wdata,
    output logic                   o_tag_we,
    output logic [INDEX_BITS-1:0]  o_tag_index,
    output logic [TAG_WIDTH-1:0]   o_tag_value,
    output logic                   o_tag_valid
);

    refill_state_e          state_q;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic                   miss_state_q;

    logic [INDEX_BITS-1:0]  idx_q;
    logic [TAG_WIDTH-1:0]   tag_q;
    logic                   unused_addr_lsb;

    logic                   accept;
    logic                   req_fire;
    logic                   beat;
    logic [OFFSET_BITS-1:0] cnt;
    logic                   cnt_last;

    assign idx_q = addr_q[OFFSET_BITS +: INDEX_BITS];
    assign tag_q = addr_q[ADDR_WIDTH-1 -: TAG_WIDTH];
    // Word offset of the missing address is irrelevant: the whole line is refilled.
    assign unused_addr_lsb = ^addr_q[OFFSET_BITS-1:0];

    // Handshakes; halt masks every one of them so nothing advances while frozen.
    assign accept   = (state_q == ST_IDLE) & i_miss_valid & ~i_halt & ~rst;
    assign req_fire = (state_q == ST_REQ)  & i_mem_req_ready & ~i_halt;
    assign beat     = (state_q == ST_FILL) & i_mem_rsp_valid & ~i_halt;

    ics_miss_refill_beat_cnt #(
        .LINE_WORDS  (LINE_WORDS),
        .OFFSET_BITS (OFFSET_BITS)
    ) u_beat_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (req_fire),
        .i_en    (beat),
        .o_count (cnt),
        .o_last  (cnt_last)
    );

    // Refill FSM with captured miss address and registered miss-state flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            miss_state_q <= 1'b0;
        end else if (!i_halt) begin
            case (state_q)
                ST_IDLE: begin
                    if (i_miss_valid) begin
                        addr_q       <= i_miss_addr;
                        state_q      <= ST_REQ;
                        miss_state_q <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (i_mem_req_ready)
                        state_q <= ST_FILL;
                end
                ST_FILL: begin
                    // Tag is only written after the final data word lands.
                    if (i_mem_rsp_valid && cnt_last)
                        state_q <= ST_TAG_WR;
                end
                ST_TAG_WR: begin
                    state_q      <= ST_IDLE;
                    miss_state_q <= 1'b0;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Miss handshake toward stage 1; ready is held low while reset is asserted.
    assign o_miss_ready = (state_q == ST_IDLE) & ~i_halt & ~rst;
    assign o_miss_state = miss_state_q;

    // Memory request: line-aligned address, stable for the whole REQ phase.
    assign o_mem_req_addr  = {tag_q, idx_q, {OFFSET_BITS{1'b0}}};
    assign o_mem_req_valid = (state_q == ST_REQ) & ~i_halt;
    assign o_mem_rsp_ready = (state_q == ST_FILL) & ~i_halt;

    // Data array write, one word per accepted beat; wdata is zero when idle.
    assign o_data_we     = beat;
    assign o_data_index  = idx_q;
    assign o_data_offset = cnt;
    assign o_data_wdata  = beat ? i_mem_rsp_data : '0;

    // Tag array write, single cycle in TAG_WR.
    assign o_tag_we    = (state_q == ST_TAG_WR) & ~i_halt;
    assign o_tag_index = idx_q;
    assign o_tag_value = tag_q;
    assign o_tag_valid = o_tag_we;

endmodule

// File: doc/ics_miss_refill.md
Name: ics_miss_refill

Overview:
- Miss-handling responder for the instruction cache: accepts a miss from the stage-1 tag compare, fetches the missing line from memory as a burst, writes the data and tag arrays, then releases the miss.
- Drives the miss-state signal that the stage-1 restart logic samples to freeze and replay the fetch address.
- Sits between the ICS1 tag-compare/restart path and the memory request/response interface.

Parameters:
- ADDR_WIDTH, 16, word address width.
- WORD_WIDTH, 16, instruction word width.
- LINE_WORDS, 4, words per line (power of 2); OFFSET_BITS = clog2(LINE_WORDS).
- NUM_SETS, 64, direct-mapped sets; INDEX_BITS = clog2(NUM_SETS); TAG_WIDTH = ADDR_WIDTH-INDEX_BITS-OFFSET_BITS.

Ports:
- clk  in  1  clock; sole clock.
- rst  in  1  synchronous, active-high reset.
- i_halt  in  1  global stall; freezes all state.
- i_miss_addr  in  ADDR_WIDTH  missing fetch address.
- i_miss_valid  in  1  miss request.
- o_miss_ready  out  1  = (state==IDLE) & ~i_halt.
- o_miss_state  out  1  high whenever state != IDLE.
- o_mem_req_addr  out  ADDR_WIDTH  line-aligned burst address (offset bits zero).
- o_mem_req_valid  out  1  burst request valid.
- i_mem_req_ready  in  1  memory accepts request.
- i_mem_rsp_data  in  WORD_WIDTH  response beat.
- i_mem_rsp_valid  in  1  beat valid.
- o_mem_rsp_ready  out  1  = (state==FILL) & ~i_halt.
- o_data_we  out  1  data array write strobe.
- o_data_index  out  INDEX_BITS  set being filled.
- o_data_offset  out  OFFSET_BITS  word within line.
- o_data_wdata  out  WORD_WIDTH  word to write.
- o_tag_we  out  1  tag array write strobe.
- o_tag_index  out  INDEX_BITS  set being tagged.
- o_tag_value  out  TAG_WIDTH  tag of the refilled line.
- o_tag_valid  out  1  valid bit written with tag (always 1 on o_tag_we).

Behaviour:
- Reset (rst high at posedge): state=IDLE, beat counter=0, captured address=0. All outputs 0 except o_miss_ready, which is 1 once rst is low and i_halt is low. Reset mid-burst abandons the line with no tag write; the memory side is reset in the same domain.
- i_halt high: state, counter and captured address hold. o_mem_req_valid, o_data_we, o_tag_we, o_mem_rsp_ready and o_miss_ready are forced 0. o_miss_state holds its value.
- FSM (registered, 2-bit): IDLE, REQ, FILL, TAG_WR.
- IDLE: on i_miss_valid & o_miss_ready, capture i_miss_addr and go to REQ. o_miss_state rises the following cycle.
- REQ: o_mem_req_valid=1 and o_mem_req_addr = {tag,index,0}, held stable until accepted. On i_mem_req_ready go to FILL with counter=0.
- FILL: each cycle with i_mem_rsp_valid & o_mem_rsp_ready asserts o_data_we combinationally, with o_data_offset=counter, o_data_wdata=i_mem_rsp_data and o_data_index=captured index. The counter then increments. On the beat where counter==LINE_WORDS-1, go to TAG_WR and wrap the counter to 0. Gaps in i_mem_rsp_valid are allowed. Beats arrive in offset order.
- TAG_WR: one cycle with o_tag_we=1, o_tag_index=captured index, o_tag_value=captured tag, o_tag_valid=1. Next state is IDLE, so o_miss_state falls and restart logic replays the held address. A new miss is accepted no earlier than the cycle after TAG_WR.
- i_miss_valid outside IDLE is ignored; the requester must hold it until o_miss_ready.
- Minimum miss latency, from acceptance to o_miss_state low: 1 (REQ) + LINE_WORDS (FILL) + 1 (TAG_WR) cycles, assuming ready and valid with no gaps.
- Data writes for a line always complete before its tag write, so the line is never tagged valid with stale words.

Decomposition:
- Shared header ics_defines.vh holds ADDR_WIDTH, WORD_WIDTH, LINE_WORDS, NUM_SETS, the derived OFFSET_BITS/INDEX_BITS/TAG_WIDTH, and the state encodings.
- Address field-split macros are shared with the ICS1 stages.
- Optional sub-module ics_beat_counter: OFFSET_BITS-wide counter with enable, clear and a last-beat flag.

Test Plan:
- Reset: hold rst 3 cycles -> all outputs 0, o_miss_state=0. Release -> o_miss_ready=1.
- Miss 0x1237, memory always ready, beats 0xA0..0xA3 back-to-back -> o_mem_req_addr=0x1234, data writes at index 0x0D offsets 0..3, tag write 0x12 valid=1. o_miss_state high exactly 6 cycles.
- Gapped beats: same miss with rsp_valid pattern 1,0,0,1,1,0,1 -> four writes in order, counter holds in gaps, TAG_WR one cycle after the 4th beat.
- Halt: assert i_halt 3 cycles during FILL after beat 1 while rsp_valid=1 -> o_mem_rsp_ready=0, no writes, counter stays at 1. Fill completes normally after release.
- Back-to-back misses: miss 0x0040 then i_miss_valid held for 0x0081 -> second accepted only after the TAG_WR of the first. The 0x0081 request goes out at 0x0080.
- Reset mid-FILL after 2 beats -> next cycle is IDLE, no tag write, o_miss_state=0. A new miss refills cleanly from offset 0.
